// File: rtl/alu_pkg.sv
// Shared definitions for the alu_seq multi-cycle ALU: opcodes, FSM states, counter sizing.
// Signed support in alu_seq is enabled by defining ALU_SIGNED_EN.
package alu_pkg;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_MUL = 2'b10;
    localparam logic [1:0] ALU_DIV = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } alu_state_e;

    // Iteration counter must be able to hold WIDTH-1 down to 0.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/alu_shift_core.sv
// Shared shift-iterate datapath: one shift-add multiply step or one restoring
// divide step per enable. {hi, lo} is the accumulator / remainder-quotient pair.
module alu_shift_core #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             load,
    input  logic             step,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] acc_hi,
    output logic [WIDTH-1:0] acc_lo
);

    logic [WIDTH:0]   hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH:0]   hi_nxt;
    logic [WIDTH-1:0] lo_nxt;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   r_sh;
    logic [WIDTH:0]   r_diff;

    always_comb begin
        mul_sum = lo[0] ? (hi + {1'b0, b}) : hi;
        r_sh    = {hi[WIDTH-1:0], lo[WIDTH-1]};
        r_diff  = r_sh - {1'b0, b};
        if (is_div) begin
            // Remainder stays below the divisor, so the top bit of hi is free.
            if (r_sh >= {1'b0, b}) begin
                hi_nxt = r_diff;
                lo_nxt = {lo[WIDTH-2:0], 1'b1};
            end else begin
                hi_nxt = r_sh;
                lo_nxt = {lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            hi_nxt = {1'b0, mul_sum[WIDTH:1]};
            lo_nxt = {mul_sum[0], lo[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            hi <= '0;
            lo <= '0;
        end else if (load) begin
            hi <= '0;
            lo <= a;
        end else if (step) begin
            hi <= hi_nxt;
            lo <= lo_nxt;
        end
    end

    assign acc_hi = hi[WIDTH-1:0];
    assign acc_lo = lo;

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ADD/SUB/MUL/DIV with start/busy/done handshake and divide-by-zero flag.
// Define ALU_SIGNED_EN for two's complement support; otherwise everything is unsigned.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 start,
    input  logic [1:0]           op,
    input  logic                 is_signed,
    input  logic [WIDTH-1:0]     src1,
    input  logic [WIDTH-1:0]     src2,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result,
    output logic                 div_zero,
    output logic                 ovf
);

    localparam int CW = cnt_width(WIDTH);

    alu_state_e         state;
    logic [1:0]         op_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [CW-1:0]      cnt;
    logic               calc_init;
    logic               core_load;
    logic               core_step;
    logic [WIDTH-1:0]   core_hi;
    logic [WIDTH-1:0]   core_lo;
    logic [WIDTH-1:0]   a_in;
    logic [WIDTH-1:0]   b_in;
    logic [WIDTH+1:0]   ext_a;
    logic [WIDTH+1:0]   ext_b;
    logic [WIDTH+1:0]   addsub;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   a_orig;
    logic [2*WIDTH-1:0] fix_res;
    logic               fix_dz;
    logic               fix_ovf;

`ifdef ALU_SIGNED_EN
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    logic sgn_q;
    logic neg_a_q;
    logic neg_b_q;
    logic neg_a;
    logic neg_b;

    assign neg_a = is_signed & src1[WIDTH-1];
    assign neg_b = is_signed & src2[WIDTH-1];
    // MUL/DIV iterate on magnitudes; ADD/SUB keep the raw two's complement operands.
    assign a_in  = (op[1] && neg_a) ? -src1 : src1;
    assign b_in  = (op[1] && neg_b) ? -src2 : src2;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sgn_q   <= 1'b0;
            neg_a_q <= 1'b0;
            neg_b_q <= 1'b0;
        end else if (state == ST_IDLE && start) begin
            sgn_q   <= is_signed;
            neg_a_q <= neg_a;
            neg_b_q <= neg_b;
        end
    end
`else
    logic unused_sgn;
    assign unused_sgn = is_signed;
    assign a_in       = src1;
    assign b_in       = src2;
`endif

    assign core_load = (state == ST_CALC) && calc_init && op_q[1];
    assign core_step = (state == ST_CALC) && !calc_init;

    alu_shift_core #(.WIDTH(WIDTH)) u_core (
        .clk    (clk),
        .n_rst  (n_rst),
        .load   (core_load),
        .step   (core_step),
        .is_div (op_q[0]),
        .a      (a_q),
        .b      (b_q),
        .acc_hi (core_hi),
        .acc_lo (core_lo)
    );

    // Two guard bits keep ADD/SUB exact before sign-extending to the full result.
    always_comb begin
        ext_a = {2'b00, a_q};
        ext_b = {2'b00, b_q};
`ifdef ALU_SIGNED_EN
        if (sgn_q) begin
            ext_a = {{2{a_q[WIDTH-1]}}, a_q};
            ext_b = {{2{b_q[WIDTH-1]}}, b_q};
        end
`endif
        addsub = (op_q == ALU_SUB) ? (ext_a - ext_b) : (ext_a + ext_b);
    end

    always_comb begin
        prod    = {core_hi, core_lo};
        quo     = core_lo;
        rem     = core_hi;
        a_orig  = a_q;
        fix_dz  = (op_q == ALU_DIV) && (b_q == '0);
        fix_ovf = 1'b0;
`ifdef ALU_SIGNED_EN
        if (neg_a_q ^ neg_b_q) begin
            prod = -prod;
            quo  = -quo;
        end
        // Remainder follows the dividend; negating the magnitude also restores src1.
        if (neg_a_q) begin
            rem    = -rem;
            a_orig = -a_q;
        end
        fix_ovf = (op_q == ALU_DIV) && neg_a_q && neg_b_q && (a_q == MIN_NEG) && (b_q == ONE);
`endif
        case (op_q)
            ALU_ADD, ALU_SUB: fix_res = {{(WIDTH-2){addsub[WIDTH+1]}}, addsub};
            ALU_MUL:          fix_res = prod;
            default:          fix_res = fix_dz ? {{WIDTH{1'b1}}, a_orig} : {quo, rem};
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= ST_IDLE;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            cnt       <= '0;
            calc_init <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            div_zero  <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state     <= ST_CALC;
                        op_q      <= op;
                        a_q       <= a_in;
                        b_q       <= b_in;
                        cnt       <= CW'(WIDTH - 1);
                        calc_init <= 1'b1;
                        busy      <= 1'b1;
                        div_zero  <= 1'b0;
                        ovf       <= 1'b0;
                    end
                end
                ST_CALC: begin
                    // First CALC cycle loads the core from the latched operands.
                    if (!op_q[1] || (calc_init && op_q == ALU_DIV && b_q == '0)) begin
                        state <= ST_FIX;
                    end else if (calc_init) begin
                        calc_init <= 1'b0;
                    end else begin
                        cnt <= cnt - CW'(1);
                        if (cnt == '0) state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    // FIX spans the done cycle so a start seen alongside done is dropped.
                    if (!done) begin
                        result   <= fix_res;
                        div_zero <= fix_dz;
                        ovf      <= fix_ovf;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                    end else begin
                        done  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq at WIDTH=16; expectations follow ALU_SIGNED_EN.
`timescale 1ns/1ps
module tb_alu_seq;

    localparam int W = 16;
`ifdef ALU_SIGNED_EN
    localparam bit SE = 1'b1;
`else
    localparam bit SE = 1'b0;
`endif
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    logic           clk = 1'b0;
    logic           n_rst = 1'b1;
    logic           start = 1'b0;
    logic [1:0]     op = 2'b00;
    logic           is_signed = 1'b0;
    logic [W-1:0]   src1 = '0;
    logic [W-1:0]   src2 = '0;
    logic           busy;
    logic           done;
    logic [2*W-1:0] result;
    logic           div_zero;
    logic           ovf;

    typedef struct {
        logic [31:0] res;
        logic        dz;
        logic        ov;
        string       nm;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;

    alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .start     (start),
        .op        (op),
        .is_signed (is_signed),
        .src1      (src1),
        .src2      (src2),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .div_zero  (div_zero),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Monitor: every done pulse consumes exactly one scoreboard entry.
    always @(negedge clk) begin
        if (n_rst && done) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got result %h with empty scoreboard, want no done", result);
            end else begin
                mon_e = sbq.pop_front();
                chk({mon_e.nm, "_res"}, result, mon_e.res);
                chk({mon_e.nm, "_dz"}, 32'(div_zero), 32'(mon_e.dz));
                chk({mon_e.nm, "_ovf"}, 32'(ovf), 32'(mon_e.ov));
            end
        end
    end

    // Called at #1 after a clock edge; start is sampled on the next edge.
    task automatic issue(input string nm, input logic [1:0] o, input logic s,
                         input logic [15:0] a, input logic [15:0] b,
                         input logic [31:0] er, input logic edz, input logic eov,
                         input int elat, input int poke, input bit poke_done);
        int lat;
        int bcnt;
        sbq.push_back('{er, edz, eov, nm});
        start = 1'b1; op = o; is_signed = s; src1 = a; src2 = b;
        @(posedge clk); #1;
        start = 1'b0; op = ~o; is_signed = ~s; src1 = ~a; src2 = ~b;
        lat  = 0;
        bcnt = busy ? 1 : 0;
        do begin
            @(posedge clk); #1;
            lat++;
            if (poke > 0 && lat == poke) start = 1'b1;
            else if (poke > 0 && lat == poke + 1) start = 1'b0;
            if (busy) bcnt++;
        end while (!done && lat < 100);
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no done after %0d cycles, want done at %0d", nm, lat, elat);
        end else begin
            chk({nm, "_lat"}, 32'(lat), 32'(elat));
            chk({nm, "_busy"}, 32'(bcnt), 32'(elat));
        end
        if (poke_done) begin
            start = 1'b1; op = OP_ADD; is_signed = 1'b0; src1 = 16'h1111; src2 = 16'h2222;
        end
        @(posedge clk); #1;
        start = 1'b0;
        chk({nm, "_hold_res"}, result, er);
        chk({nm, "_hold_flags"}, 32'({div_zero, ovf}), 32'({edz, eov}));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #2 n_rst = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_result", result, 0);
        chk("rst_flags", 32'({div_zero, ovf}), 0);
        repeat (2) @(posedge clk);
        #1 n_rst = 1'b1;
        @(posedge clk); #1;

        issue("add_u_carry", OP_ADD, 1'b0, 16'hFFFF, 16'h0001, 32'h0001_0000, 0, 0, 2, 0, 0);
        issue("sub_s",       OP_SUB, 1'b1, 16'h0003, 16'h0005, 32'hFFFF_FFFE, 0, 0, 2, 0, 0);
        issue("sub_u",       OP_SUB, 1'b0, 16'h0003, 16'h0005, 32'hFFFF_FFFE, 0, 0, 2, 0, 0);
        issue("add_s_min",   OP_ADD, 1'b1, 16'h8000, 16'h8000,
              SE ? 32'hFFFF_0000 : 32'h0001_0000, 0, 0, 2, 0, 0);
        issue("add_u_wrap",  OP_ADD, 1'b0, 16'hFFFF, 16'hFFFF, 32'h0001_FFFE, 0, 0, 2, 0, 0);
        issue("mul_s",       OP_MUL, 1'b1, 16'hFFFD, 16'h0007,
              SE ? 32'hFFFF_FFEB : 32'h0006_FFEB, 0, 0, 18, 0, 0);
        issue("mul_u_max",   OP_MUL, 1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 0, 0, 18, 0, 0);
        issue("mul_s_negneg", OP_MUL, 1'b1, 16'hFFFF, 16'hFFFF,
              SE ? 32'h0000_0001 : 32'hFFFE_0001, 0, 0, 18, 0, 0);
        issue("div_s",       OP_DIV, 1'b1, 16'hFFF9, 16'h0002,
              SE ? 32'hFFFD_FFFF : 32'h7FFC_0001, 0, 0, 18, 0, 0);
        issue("div_s_posneg", OP_DIV, 1'b1, 16'h0007, 16'hFFFE,
              SE ? 32'hFFFD_0001 : 32'h0000_0007, 0, 0, 18, 0, 0);
        issue("div_s_ovf",   OP_DIV, 1'b1, 16'h8000, 16'hFFFF,
              SE ? 32'h8000_0000 : 32'h0000_8000, 0, SE, 18, 0, 0);

        // Reset in the middle of a MUL aborts it; no done may follow.
        start = 1'b1; op = OP_MUL; is_signed = 1'b0; src1 = 16'h0007; src2 = 16'h0009;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("mid_mul_busy", 32'(busy), 1);
        n_rst = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_done", 32'(done), 0);
        chk("midrst_result", result, 0);
        chk("midrst_flags", 32'({div_zero, ovf}), 0);
        @(posedge clk); #1;
        n_rst = 1'b1;
        repeat (25) @(posedge clk);
        #1;
        chk("postrst_busy", 32'(busy), 0);

        issue("div_zero_u",  OP_DIV, 1'b0, 16'h1234, 16'h0000, 32'hFFFF_1234, 1, 0, 2, 0, 0);
        issue("div_zero_s",  OP_DIV, 1'b1, 16'hFFF9, 16'h0000, 32'hFFFF_FFF9, 1, 0, 2, 0, 0);
        issue("mul_poke",    OP_MUL, 1'b0, 16'h1234, 16'h0010, 32'h0001_2340, 0, 0, 18, 3, 1);
        issue("sub_b2b",     OP_SUB, 1'b0, 16'h0000, 16'h0001, 32'hFFFF_FFFF, 0, 0, 2, 0, 0);
        issue("div_u",       OP_DIV, 1'b0, 16'h0064, 16'h0007, 32'h000E_0002, 0, 0, 18, 0, 0);

        repeat (5) @(posedge clk);
        #1;
        chk("sb_empty", 32'(sbq.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
